// File: rtl/led_status_ctrl.sv
// Multi-channel LED status driver: per-channel off/on/slow/fast/blink-code modes,
// each channel with its own tick prescaler and phase counters.
module led_status_ctrl #(
    parameter int NUM_LED    = 6,
    parameter int TICK_DIV   = 6_250_000,
    parameter int CNT_W      = 23,
    parameter int FAST_TICKS = 1,
    parameter int SLOW_TICKS = 4,
    parameter int GAP_TICKS  = 8,
    parameter int CODE_W     = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3*NUM_LED-1:0]       mode,
    input  logic [CODE_W*NUM_LED-1:0]  code,
    output logic [NUM_LED-1:0]         led,
    output logic [NUM_LED-1:0]         code_done
);

    localparam int PH_MAX_A = (FAST_TICKS > SLOW_TICKS) ? FAST_TICKS : SLOW_TICKS;
    localparam int PH_MAX   = (PH_MAX_A > GAP_TICKS) ? PH_MAX_A : GAP_TICKS;
    localparam int PH_W     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PH_W-1:0]   FAST_LAST = PH_W'(FAST_TICKS - 1);
    localparam logic [PH_W-1:0]   SLOW_LAST = PH_W'(SLOW_TICKS - 1);
    localparam logic [PH_W-1:0]   GAP_LAST  = PH_W'(GAP_TICKS - 1);
    localparam logic [PH_W-1:0]   PH_ONE    = PH_W'(1);
    localparam logic [CODE_W-1:0] CODE_ONE  = CODE_W'(1);

    localparam logic [2:0] MODE_OFF  = 3'd0;
    localparam logic [2:0] MODE_ON   = 3'd1;
    localparam logic [2:0] MODE_SLOW = 3'd2;
    localparam logic [2:0] MODE_FAST = 3'd3;
    localparam logic [2:0] MODE_CODE = 3'd4;

    typedef enum logic [1:0] {
        PULSE_ON,
        PULSE_OFF,
        GAP
    } code_state_t;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LED; gi++) begin : g_ch
            logic [2:0]        mode_in;
            logic [CODE_W-1:0] code_in;
            logic              tick;
            logic [PH_W-1:0]   half_last;

            logic [2:0]        mode_q,  mode_d;
            logic [CNT_W-1:0]  cnt_q,   cnt_d;
            logic [PH_W-1:0]   ph_q,    ph_d;
            logic [CODE_W-1:0] pulse_q, pulse_d;
            logic [CODE_W-1:0] code_q,  code_d;
            code_state_t       state_q, state_d;
            logic              level_q, level_d;
            logic              done_q,  done_d;

            assign mode_in   = mode[3*gi +: 3];
            assign code_in   = code[CODE_W*gi +: CODE_W];
            assign tick      = (cnt_q == CNT_LAST);
            assign half_last = (mode_q == MODE_FAST) ? FAST_LAST : SLOW_LAST;

            always_comb begin
                mode_d  = mode_q;
                cnt_d   = cnt_q;
                ph_d    = ph_q;
                pulse_d = pulse_q;
                code_d  = code_q;
                state_d = state_q;
                level_d = level_q;
                done_d  = 1'b0;

                // A mode change restarts the channel and overrides any tick on this edge
                if (mode_in != mode_q) begin
                    mode_d  = mode_in;
                    cnt_d   = '0;
                    ph_d    = '0;
                    pulse_d = '0;
                    code_d  = '0;
                    state_d = GAP;
                    case (mode_in)
                        MODE_ON, MODE_SLOW, MODE_FAST: level_d = 1'b1;
                        MODE_CODE: begin
                            code_d = code_in;
                            if (code_in != '0) begin
                                state_d = PULSE_ON;
                                level_d = 1'b1;
                            end else begin
                                level_d = 1'b0;
                            end
                        end
                        default: level_d = 1'b0;
                    endcase
                end else begin
                    cnt_d = tick ? '0 : cnt_q + CNT_ONE;
                    if (tick) begin
                        case (mode_q)
                            MODE_SLOW, MODE_FAST: begin
                                if (ph_q == half_last) begin
                                    ph_d    = '0;
                                    level_d = ~level_q;
                                end else begin
                                    ph_d = ph_q + PH_ONE;
                                end
                            end
                            MODE_CODE: begin
                                case (state_q)
                                    PULSE_ON: begin
                                        state_d = PULSE_OFF;
                                        level_d = 1'b0;
                                    end
                                    PULSE_OFF: begin
                                        if (pulse_q == code_q - CODE_ONE) begin
                                            state_d = GAP;
                                            pulse_d = '0;
                                            ph_d    = '0;
                                            level_d = 1'b0;
                                        end else begin
                                            pulse_d = pulse_q + CODE_ONE;
                                            state_d = PULSE_ON;
                                            level_d = 1'b1;
                                        end
                                    end
                                    default: begin
                                        if (ph_q == GAP_LAST) begin
                                            // Sequence restart: re-sample the code
                                            ph_d    = '0;
                                            pulse_d = '0;
                                            done_d  = 1'b1;
                                            code_d  = code_in;
                                            if (code_in != '0) begin
                                                state_d = PULSE_ON;
                                                level_d = 1'b1;
                                            end else begin
                                                state_d = GAP;
                                                level_d = 1'b0;
                                            end
                                        end else begin
                                            ph_d = ph_q + PH_ONE;
                                        end
                                    end
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    mode_q  <= MODE_OFF;
                    cnt_q   <= '0;
                    ph_q    <= '0;
                    pulse_q <= '0;
                    code_q  <= '0;
                    state_q <= GAP;
                    level_q <= 1'b0;
                    done_q  <= 1'b0;
                end else begin
                    mode_q  <= mode_d;
                    cnt_q   <= cnt_d;
                    ph_q    <= ph_d;
                    pulse_q <= pulse_d;
                    code_q  <= code_d;
                    state_q <= state_d;
                    level_q <= level_d;
                    done_q  <= done_d;
                end
            end

            assign led[gi]       = level_q ^ ACTIVE_LOW;
            assign code_done[gi] = done_q;
        end
    endgenerate

endmodule

// File: tb/tb_led_status_ctrl.sv
// Bench for led_status_ctrl: directed vector table plus randomized run against
// an arithmetic reference model (elapsed-time based), on both output polarities.
module tb_led_status_ctrl;

    localparam int N    = 6;
    localparam int DIV  = 4;
    localparam int FT   = 1;
    localparam int ST   = 2;
    localparam int GT   = 3;
    localparam int CW   = 4;

    logic              clk;
    logic              reset;
    logic [3*N-1:0]    mode;
    logic [CW*N-1:0]   code;
    logic [N-1:0]      led, led_al;
    logic [N-1:0]      code_done, code_done_al;

    int checks = 0;
    int errors = 0;

    led_status_ctrl #(
        .NUM_LED(N), .TICK_DIV(DIV), .CNT_W(2), .FAST_TICKS(FT), .SLOW_TICKS(ST),
        .GAP_TICKS(GT), .CODE_W(CW), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .code(code),
        .led(led), .code_done(code_done)
    );

    led_status_ctrl #(
        .NUM_LED(N), .TICK_DIV(DIV), .CNT_W(2), .FAST_TICKS(FT), .SLOW_TICKS(ST),
        .GAP_TICKS(GT), .CODE_W(CW), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .reset(reset), .mode(mode), .code(code),
        .led(led_al), .code_done(code_done_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode in effect, cycles since it became visible,
    // position inside the current code sequence and that sequence's pulse count.
    int m_mode [N];
    int m_el   [N];
    int m_seq  [N];
    int m_code [N];
    bit m_done [N];

    function automatic logic exp_level(int ch);
        case (m_mode[ch])
            1: return 1'b1;
            2: return ((m_el[ch] / (ST * DIV)) % 2) == 0;
            3: return ((m_el[ch] / (FT * DIV)) % 2) == 0;
            4: return (m_seq[ch] < 2 * m_code[ch] * DIV) && (((m_seq[ch] / DIV) % 2) == 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_edge();
        for (int ch = 0; ch < N; ch++) begin
            int mi;
            int ci;
            mi = int'(mode[3*ch +: 3]);
            ci = int'(code[CW*ch +: CW]);
            m_done[ch] = 1'b0;
            if (reset) begin
                m_mode[ch] = 0; m_el[ch] = 0; m_seq[ch] = 0; m_code[ch] = 0;
            end else if (mi != m_mode[ch]) begin
                m_mode[ch] = mi; m_el[ch] = 0; m_seq[ch] = 0;
                m_code[ch] = (mi == 4) ? ci : 0;
            end else begin
                m_el[ch]++;
                if (m_mode[ch] == 4) begin
                    m_seq[ch]++;
                    if (m_seq[ch] == (2 * m_code[ch] + GT) * DIV) begin
                        m_seq[ch]  = 0;
                        m_code[ch] = ci;
                        m_done[ch] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        logic [N-1:0] el, ed;
        @(posedge clk);
        model_edge();
        #1;
        for (int ch = 0; ch < N; ch++) begin
            el[ch] = exp_level(ch);
            ed[ch] = m_done[ch];
        end
        chk("model_led", led, el);
        chk("model_done", code_done, ed);
        chk("model_led_al", led_al, ~el);
        chk("model_done_al", code_done_al, ed);
    endtask

    typedef struct {
        logic           rst;
        logic [3*N-1:0] md;
        logic [CW*N-1:0] cd;
        int             n;
        logic [N-1:0]   led;
        logic [N-1:0]   done;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3*N-1:0] md, input logic [CW*N-1:0] cd,
                       input int n, input logic [N-1:0] l, input logic [N-1:0] d);
        vec_t v;
        v.rst = r; v.md = md; v.cd = cd; v.n = n; v.led = l; v.done = d;
        tbl.push_back(v);
    endtask

    initial begin
        reset = 1'b1;
        mode  = 18'o333333;
        code  = '0;
        for (int ch = 0; ch < N; ch++) begin
            m_mode[ch] = 0; m_el[ch] = 0; m_seq[ch] = 0; m_code[ch] = 0; m_done[ch] = 0;
        end

        // reset, on, fast blink
        add(1, 18'o333333, 24'h000000, 3, 6'h00, 6'h00);
        add(0, 18'o000000, 24'h000000, 1, 6'h00, 6'h00);
        add(0, 18'o000001, 24'h000000, 1, 6'h01, 6'h00);
        add(0, 18'o000001, 24'h000000, 5, 6'h01, 6'h00);
        add(0, 18'o000031, 24'h000000, 1, 6'h03, 6'h00);
        add(0, 18'o000031, 24'h000000, 3, 6'h03, 6'h00);
        add(0, 18'o000031, 24'h000000, 1, 6'h01, 6'h00);
        add(0, 18'o000031, 24'h000000, 3, 6'h01, 6'h00);
        add(0, 18'o000031, 24'h000000, 1, 6'h03, 6'h00);
        // slow blink, mid-phase switch off and back
        add(0, 18'o000201, 24'h000000, 1, 6'h05, 6'h00);
        add(0, 18'o000201, 24'h000000, 7, 6'h05, 6'h00);
        add(0, 18'o000201, 24'h000000, 1, 6'h01, 6'h00);
        add(0, 18'o000201, 24'h000000, 8, 6'h05, 6'h00);
        add(0, 18'o000201, 24'h000000, 4, 6'h05, 6'h00);
        add(0, 18'o000001, 24'h000000, 1, 6'h01, 6'h00);
        add(0, 18'o000201, 24'h000000, 1, 6'h05, 6'h00);
        add(0, 18'o000201, 24'h000000, 7, 6'h05, 6'h00);
        add(0, 18'o000201, 24'h000000, 1, 6'h01, 6'h00);
        // code 3, then code 1 applied mid-sequence
        add(0, 18'o004001, 24'h003000, 1, 6'h09, 6'h00);
        add(0, 18'o004001, 24'h003000, 3, 6'h09, 6'h00);
        add(0, 18'o004001, 24'h003000, 1, 6'h01, 6'h00);
        add(0, 18'o004001, 24'h003000, 4, 6'h09, 6'h00);
        add(0, 18'o004001, 24'h001000, 8, 6'h09, 6'h00);
        add(0, 18'o004001, 24'h001000, 4, 6'h01, 6'h00);
        add(0, 18'o004001, 24'h001000, 4, 6'h01, 6'h00);
        add(0, 18'o004001, 24'h001000, 11, 6'h01, 6'h00);
        add(0, 18'o004001, 24'h001000, 1, 6'h09, 6'h08);
        add(0, 18'o004001, 24'h001000, 1, 6'h09, 6'h00);
        add(0, 18'o004001, 24'h001000, 3, 6'h01, 6'h00);
        add(0, 18'o004001, 24'h001000, 4, 6'h01, 6'h00);
        add(0, 18'o004001, 24'h001000, 11, 6'h01, 6'h00);
        add(0, 18'o004001, 24'h001000, 1, 6'h09, 6'h08);
        // code 0: dark, done every 12 clocks
        add(0, 18'o040001, 24'h000000, 1, 6'h01, 6'h00);
        add(0, 18'o040001, 24'h000000, 11, 6'h01, 6'h00);
        add(0, 18'o040001, 24'h000000, 1, 6'h01, 6'h10);
        add(0, 18'o040001, 24'h000000, 12, 6'h01, 6'h10);
        // mode change on the tick edge that would have toggled slow blink off
        add(0, 18'o000201, 24'h000000, 8, 6'h05, 6'h00);
        add(0, 18'o000301, 24'h000000, 1, 6'h05, 6'h00);
        add(0, 18'o000301, 24'h000000, 4, 6'h01, 6'h00);
        // reset during pulse 2 of code 3, then full restart
        add(0, 18'o004001, 24'h003000, 9, 6'h09, 6'h00);
        add(1, 18'o004001, 24'h003000, 1, 6'h00, 6'h00);
        add(0, 18'o004001, 24'h003000, 1, 6'h09, 6'h00);
        add(0, 18'o004001, 24'h003000, 3, 6'h09, 6'h00);
        add(0, 18'o004001, 24'h003000, 1, 6'h01, 6'h00);

        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            mode  = tbl[i].md;
            code  = tbl[i].cd;
            repeat (tbl[i].n) step();
            chk($sformatf("tbl%0d_led", i), led, tbl[i].led);
            chk($sformatf("tbl%0d_done", i), code_done, tbl[i].done);
            chk($sformatf("tbl%0d_led_al", i), led_al, ~tbl[i].led);
            $display("vec %0d rst=%0b mode=%o code=%h n=%0d led=%h done=%h", i, tbl[i].rst,
                     tbl[i].md, tbl[i].cd, tbl[i].n, led, code_done);
        end

        // Randomized run: sparse mode/code changes, occasional reset, toggles
        reset = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int ch;
            ch = int'($urandom_range(0, N - 1));
            if ($urandom_range(0, 29) == 0)
                mode[3*ch +: 3] = 3'($urandom_range(0, 7));
            else if ($urandom_range(0, 19) == 0)
                mode[3*ch +: 3] = 3'($urandom_range(2, 4));
            if ($urandom_range(0, 24) == 0)
                code[CW*ch +: CW] = 4'($urandom_range(0, 3));
            reset = ($urandom_range(0, 599) == 0);
            step();
            if ($urandom_range(0, 199) == 0) begin
                logic [2:0] keep;
                keep = mode[3*ch +: 3];
                mode[3*ch +: 3] = keep ^ 3'd1;
                reset = 1'b0;
                step();
                mode[3*ch +: 3] = keep;
                step();
            end
        end
        $display("random phase done led=%h done=%h", led, code_done);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
